// File: rtl/usm_window_sum_sequencer.sv
// Multi-cycle window summer: captures one LENGTH-pixel window and folds it through a
// shared CHUNK-input adder tree, one pass per cycle, then holds the total on a valid/ready port.
module usm_window_sum_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 49,
  parameter int CHUNK      = 7,
  parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(LENGTH),
  parameter int NUM_PASS   = (LENGTH + CHUNK - 1) / CHUNK
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_window,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_WIDTH-1:0]         out_sum,
  output logic                         busy
);

  localparam int TREE_W  = DATA_WIDTH + $clog2(CHUNK);
  localparam int PASS_W  = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
  localparam int PAD_LEN = NUM_PASS * CHUNK;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                         state, state_nxt;
  logic [LENGTH*DATA_WIDTH-1:0]   win_q;
  logic [PAD_LEN*DATA_WIDTH-1:0]  win_pad;
  logic [CHUNK*DATA_WIDTH-1:0]    chunk_vec;
  logic [PASS_W-1:0]              pass_idx;
  logic [SUM_WIDTH-1:0]           acc;
  logic [SUM_WIDTH-1:0]           acc_nxt;
  logic [TREE_W-1:0]              tree_out;

  // Balanced pairwise reduction; odd leftovers ride up to the next level unchanged.
  function automatic logic [TREE_W-1:0] tree_sum(input logic [CHUNK*DATA_WIDTH-1:0] v);
    logic [TREE_W-1:0] lvl [CHUNK];
    for (int i = 0; i < CHUNK; i++) lvl[i] = TREE_W'(v[i*DATA_WIDTH +: DATA_WIDTH]);
    for (int n = CHUNK; n > 1; n = (n + 1) / 2) begin
      for (int j = 0; j < n / 2; j++) lvl[j] = lvl[2*j] + lvl[2*j+1];
      if (n % 2 == 1) lvl[n/2] = lvl[n-1];
    end
    return lvl[0];
  endfunction

  // Pixels past LENGTH on the final pass read as zero padding.
  always_comb begin
    win_pad = '0;
    win_pad[LENGTH*DATA_WIDTH-1:0] = win_q;
    chunk_vec = win_pad[int'(pass_idx)*CHUNK*DATA_WIDTH +: CHUNK*DATA_WIDTH];
    tree_out  = tree_sum(chunk_vec);
    acc_nxt   = acc + SUM_WIDTH'(tree_out);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (pass_idx == LAST_PASS) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture / accumulate stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q    <= '0;
      acc      <= '0;
      pass_idx <= '0;
      out_sum  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            win_q    <= in_window;
            acc      <= '0;
            pass_idx <= '0;
          end
        end
        S_ACCUM: begin
          acc <= acc_nxt;
          if (pass_idx == LAST_PASS) begin
            out_sum  <= acc_nxt;
            pass_idx <= '0;
          end else begin
            pass_idx <= pass_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usm_window_sum_sequencer.sv
// Bench for usm_window_sum_sequencer: three configurations (49/7, 10/4, 5/5) compared
// against plain pixel sums, with latency, backpressure, streaming and reset-abort scenarios.
module tb_usm_window_sum_sequencer;

  localparam int DW  = 8;
  localparam int LA  = 49, CA = 7, SA = DW + $clog2(LA);
  localparam int LB  = 10, CB = 4, SB = DW + $clog2(LB);
  localparam int LC  = 5,  CC = 5, SC = DW + $clog2(LC);
  localparam int TMO = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_busy;
  logic [LA*DW-1:0] a_in_window = '0;
  logic [SA-1:0]    a_out_sum;
  logic             b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_busy;
  logic [LB*DW-1:0] b_in_window = '0;
  logic [SB-1:0]    b_out_sum;
  logic             c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_busy;
  logic [LC*DW-1:0] c_in_window = '0;
  logic [SC-1:0]    c_out_sum;

  int errors = 0;
  int checks = 0;

  usm_window_sum_sequencer #(.DATA_WIDTH(DW), .LENGTH(LA), .CHUNK(CA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_window(a_in_window), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .busy(a_busy));

  usm_window_sum_sequencer #(.DATA_WIDTH(DW), .LENGTH(LB), .CHUNK(CB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_window(b_in_window), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .busy(b_busy));

  usm_window_sum_sequencer #(.DATA_WIDTH(DW), .LENGTH(LC), .CHUNK(CC)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_window(c_in_window), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .busy(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_win_a(output logic [LA*DW-1:0] w, output int e);
    int p;
    e = 0;
    for (int i = 0; i < LA; i++) begin
      p = int'($urandom_range(0, 255));
      w[i*DW +: DW] = DW'(p);
      e += p;
    end
  endtask

  task automatic scramble_a();
    for (int i = 0; i < LA; i++) a_in_window[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic send_a(input logic [LA*DW-1:0] w);
    a_in_valid  = 1'b1;
    a_in_window = w;
    tick();
    a_in_valid = 1'b0;
    scramble_a();
  endtask

  task automatic wait_valid_a(output int lat, output int busy_n);
    lat    = 0;
    busy_n = a_busy ? 1 : 0;
    while (!a_out_valid && lat < TMO) begin
      tick();
      lat++;
      if (a_busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %0d expected 0", a_out_sum); end
    checks++; if (b_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin errors++; $display("FAIL reset_bc_valid: got %b%b expected 00", b_out_valid, c_out_valid); end
    rst_n = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready=%b busy=%b expected 1/0", a_in_ready, a_busy); end
  endtask

  task automatic test_single();
    logic [LA*DW-1:0] w;
    int e, lat, bn;
    e = 0;
    for (int i = 0; i < LA; i++) begin w[i*DW +: DW] = DW'(i); e += i; end
    a_out_ready = 1'b1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL single_ready_before: got %b expected 1", a_in_ready); end
    send_a(w);
    wait_valid_a(lat, bn);
    checks++; if (lat !== 7) begin errors++; $display("FAIL single_latency: got %0d expected 7", lat); end
    checks++; if (a_out_sum !== SA'(e)) begin errors++; $display("FAIL single_sum: got %0d expected %0d", a_out_sum, e); end
    tick();
    if (a_busy) bn++;
    checks++; if (bn !== 8) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 8", bn); end
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL single_after_hs: ready=%b valid=%b expected 1/0", a_in_ready, a_out_valid); end
    checks++; if (a_out_sum !== SA'(e)) begin errors++; $display("FAIL single_sum_kept: got %0d expected %0d", a_out_sum, e); end
  endtask

  task automatic test_all_max();
    logic [LA*DW-1:0] w;
    int e, lat, bn;
    e = 0;
    for (int i = 0; i < LA; i++) begin w[i*DW +: DW] = 8'hFF; e += 255; end
    send_a(w);
    wait_valid_a(lat, bn);
    checks++; if (lat !== 7) begin errors++; $display("FAIL max_latency: got %0d expected 7", lat); end
    checks++; if (a_out_sum !== SA'(e)) begin errors++; $display("FAIL max_sum: got %0d expected %0d", a_out_sum, e); end
    tick();
  endtask

  task automatic test_nondiv();
    logic [LB*DW-1:0] w;
    int e, p, lat;
    for (int r = 0; r < 3; r++) begin
      e = 0;
      for (int i = 0; i < LB; i++) begin
        p = (r == 0) ? i + 1 : (r == 1) ? 255 : int'($urandom_range(0, 255));
        w[i*DW +: DW] = DW'(p);
        e += p;
      end
      b_in_valid  = 1'b1;
      b_in_window = w;
      tick();
      b_in_valid = 1'b0;
      for (int i = 0; i < LB; i++) b_in_window[i*DW +: DW] = DW'($urandom);
      lat = 0;
      while (!b_out_valid && lat < TMO) begin tick(); lat++; end
      checks++; if (lat !== 3) begin errors++; $display("FAIL nondiv_latency[%0d]: got %0d expected 3", r, lat); end
      checks++; if (b_out_sum !== SB'(e)) begin errors++; $display("FAIL nondiv_sum[%0d]: got %0d expected %0d", r, b_out_sum, e); end
      tick();
      checks++; if (b_busy !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL nondiv_idle[%0d]: busy=%b ready=%b expected 0/1", r, b_busy, b_in_ready); end
    end
  endtask

  task automatic test_single_pass();
    logic [LC*DW-1:0] w;
    int e, p, lat;
    for (int r = 0; r < 3; r++) begin
      e = 0;
      for (int i = 0; i < LC; i++) begin
        p = (r == 0) ? 255 : int'($urandom_range(0, 255));
        w[i*DW +: DW] = DW'(p);
        e += p;
      end
      c_in_valid  = 1'b1;
      c_in_window = w;
      tick();
      c_in_valid  = 1'b0;
      c_in_window = '0;
      lat = 0;
      while (!c_out_valid && lat < TMO) begin tick(); lat++; end
      checks++; if (lat !== 1) begin errors++; $display("FAIL onepass_latency[%0d]: got %0d expected 1", r, lat); end
      checks++; if (c_out_sum !== SC'(e)) begin errors++; $display("FAIL onepass_sum[%0d]: got %0d expected %0d", r, c_out_sum, e); end
      tick();
      checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL onepass_idle[%0d]: busy=%b expected 0", r, c_busy); end
    end
  endtask

  task automatic test_backpressure();
    logic [LA*DW-1:0] w1, w2;
    int e1, e2, lat, bn;
    rand_win_a(w1, e1);
    rand_win_a(w2, e2);
    a_out_ready = 1'b0;
    send_a(w1);
    wait_valid_a(lat, bn);
    checks++; if (lat !== 7) begin errors++; $display("FAIL bp_latency: got %0d expected 7", lat); end
    a_in_valid  = 1'b1;
    a_in_window = w2;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held[%0d]: got %b expected 1", k, a_out_valid); end
      checks++; if (a_out_sum !== SA'(e1)) begin errors++; $display("FAIL bp_sum_held[%0d]: got %0d expected %0d", k, a_out_sum, e1); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, a_in_ready); end
    end
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_hs: valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    tick();
    a_in_valid = 1'b0;
    scramble_a();
    wait_valid_a(lat, bn);
    checks++; if (lat !== 7) begin errors++; $display("FAIL bp_second_latency: got %0d expected 7", lat); end
    checks++; if (a_out_sum !== SA'(e2)) begin errors++; $display("FAIL bp_second_sum: got %0d expected %0d", a_out_sum, e2); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [LA*DW-1:0] wins [4];
    int exps [4];
    int acc_cyc [4];
    int got [4];
    int idx, ng, cyc;
    logic take;
    for (int k = 0; k < 4; k++) rand_win_a(wins[k], exps[k]);
    a_out_ready = 1'b1;
    idx = 0; ng = 0; cyc = 0;
    a_in_valid  = 1'b1;
    a_in_window = wins[0];
    while ((idx < 4 || ng < 4) && cyc < TMO) begin
      take = a_in_valid && a_in_ready;
      tick();
      cyc++;
      if (take) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) a_in_window = wins[idx];
        else a_in_valid = 1'b0;
      end
      if (a_out_valid) begin
        if (ng < 4) got[ng] = int'(a_out_sum);
        ng++;
      end
    end
    a_in_valid = 1'b0;
    checks++; if (ng !== 4 || idx !== 4) begin errors++; $display("FAIL b2b_count: got %0d outputs %0d accepts expected 4/4", ng, idx); end
    for (int k = 0; k < 4; k++) begin
      if (k < ng) begin
        checks++; if (got[k] !== exps[k]) begin errors++; $display("FAIL b2b_sum[%0d]: got %0d expected %0d", k, got[k], exps[k]); end
      end
      if (k > 0 && k < idx) begin
        checks++; if (acc_cyc[k] - acc_cyc[k-1] !== 9) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 9", k, acc_cyc[k] - acc_cyc[k-1]); end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [LA*DW-1:0] w;
    int e, lat, bn;
    rand_win_a(w, e);
    send_a(w);
    repeat (3) tick();
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", a_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL abort_accum: valid=%b busy=%b ready=%b expected 0/0/1", a_out_valid, a_busy, a_in_ready); end
    #1 rst_n = 1'b1;
    tick();
    rand_win_a(w, e);
    a_out_ready = 1'b0;
    send_a(w);
    wait_valid_a(lat, bn);
    checks++; if (a_out_sum !== SA'(e)) begin errors++; $display("FAIL abort_next_sum: got %0d expected %0d", a_out_sum, e); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL abort_done: valid=%b busy=%b ready=%b expected 0/0/1", a_out_valid, a_busy, a_in_ready); end
    #1 rst_n = 1'b1;
    a_out_ready = 1'b1;
    tick();
    rand_win_a(w, e);
    send_a(w);
    wait_valid_a(lat, bn);
    checks++; if (lat !== 7) begin errors++; $display("FAIL abort_final_latency: got %0d expected 7", lat); end
    checks++; if (a_out_sum !== SA'(e)) begin errors++; $display("FAIL abort_final_sum: got %0d expected %0d", a_out_sum, e); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_max();
    test_nondiv();
    test_single_pass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usm_window_sum_sequencer.md
Name: usm_window_sum_sequencer

Overview:
- Sums one LENGTH-pixel unsigned window (e.g. a 7x7 USM blur kernel) over several cycles through one shared CHUNK-input unsigned adder tree.
- Slices the captured window into CHUNK-wide passes, feeds one pass per cycle into the tree and accumulates the partial sums.
- Presents the total on a valid/ready output.
- Sits between the USM line-buffer window generator and the USM blur/sharpen arithmetic stage. It trades throughput for adder area.

Parameters:
- DATA_WIDTH, 8, width of each unsigned pixel.
- LENGTH, 49, pixels per window.
- CHUNK, 7, pixels summed per pass (tree input count); 1 <= CHUNK <= LENGTH.
- SUM_WIDTH, DATA_WIDTH+$clog2(LENGTH), width of out_sum.
- NUM_PASS, ceil(LENGTH/CHUNK), derived; do not override.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  window present on in_window.
- in_ready  out  1  block can accept a window.
- in_window  in  LENGTH*DATA_WIDTH  packed pixels; pixel i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_sum holds a completed sum.
- out_ready  in  1  downstream accepts out_sum.
- out_sum  out  SUM_WIDTH  unsigned window sum.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pass_idx=0, acc=0, out_sum=0, out_valid=0, busy=0, window register=0. in_ready=1 while in IDLE, including during reset.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready edge: latch in_window into the internal register, clear acc and pass_idx, go to ACCUM. in_window is ignored after the accept edge.
  - ACCUM: each edge adds the tree sum of register pixels [pass_idx*CHUNK, pass_idx*CHUNK+CHUNK-1] to acc and increments pass_idx.
    - Pixel indices >= LENGTH on the last pass are fed as zero.
    - On the edge where pass_idx==NUM_PASS-1: out_sum <= acc + tree sum, out_valid <= 1, go to DONE.
  - DONE: out_valid=1. out_sum and out_valid are held stable while out_ready=0. On an out_valid&&out_ready edge: out_valid <= 0, go to IDLE. out_sum keeps its last value after the handshake.
- in_ready=0 in ACCUM and DONE. in_valid is ignored there and no window is dropped: upstream must hold it.
- Latency:
  - out_valid rises NUM_PASS edges after the accept edge.
  - Minimum throughput is one window per NUM_PASS+2 cycles with out_ready tied high. For 49/7 that is valid 7 edges after accept and 9-cycle spacing.
- NUM_PASS==1 (CHUNK==LENGTH): ACCUM lasts one cycle; out_valid rises 1 edge after accept.
- Arithmetic and widths:
  - Tree output is DATA_WIDTH+$clog2(CHUNK) bits; acc is SUM_WIDTH bits.
  - All adds are unsigned and zero-extended. Overflow is impossible by construction; no saturation.
- Tree: one combinational unsigned adder tree instance of CHUNK inputs, fed by a mux over pass_idx. There is no register inside the tree; the tree-to-acc path is single-cycle.
- Reset mid-operation: any state returns to IDLE immediately. The partial acc is discarded and out_valid drops asynchronously. No output handshake occurs for the aborted window.
- in_valid and out_ready are never combinationally fed to each other's outputs; in_ready depends only on state.

Test Plan:
- Reset then single window, LENGTH=49/CHUNK=7, pixel i=i, out_ready=1 -> out_valid rises exactly 7 edges after accept; out_sum=1176; busy high for 8 cycles; in_ready returns high on the cycle after the output handshake.
- All pixels 255, LENGTH=49/CHUNK=7 -> out_sum=12495 (0x30CF, fits 14 bits); no overflow.
- Non-divisible config LENGTH=10/CHUNK=4, pixels 1..10 -> NUM_PASS=3; out_sum=55; padded pixels contribute 0; valid 3 edges after accept.
- Backpressure: out_ready low for 5 cycles in DONE while in_valid held high with a new window -> out_sum/out_valid stable, in_ready=0, second window not accepted until after the output handshake; second sum then correct.
- Back-to-back stream of 4 windows with random pixels, out_ready=1 -> sums match a reference model in order; accepts spaced exactly 9 cycles apart.
- rst_n pulsed low at pass 3 of ACCUM -> out_valid=0, busy=0, in_ready=1 immediately; the next window sums correctly with no residue from the aborted acc.
